// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command sequencer: state encoding, default
// phase lengths and the queued command layout.
package i2c_pkg;

  localparam int unsigned CNT_W           = 24;
  localparam int unsigned LEVEL_W         = 7;
  localparam int unsigned I2C_FRAME_BITS  = 168;
  localparam int unsigned DEF_HOLD_CYCLES = 131072;
  localparam int unsigned DEF_WAIT_CYCLES = 6291456;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ASSERT = 2'd2,
    WAIT   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [1:0]  lines;
    logic [15:0] data12;
    logic [15:0] data34;
  } i2c_cmd_t;

  localparam int unsigned CMD_W = $bits(i2c_cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, registered level/full
// and a sticky overflow flag for pushes that find no free slot.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_c,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic [LEVEL_W-1:0] level_nxt;

  // A pop in the same cycle frees a slot, so a push at full is still taken
  assign pop_ok  = pop && (level != '0);
  assign push_ok = push && (!full || pop_ok);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LEVEL_W'(1);
    end else if (!push_ok && pop_ok) begin
      level_nxt = level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LEVEL_W'(DEPTH));
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Pops queued I2C commands and drives the transmitter through a
// LOAD / ASSERT (ENABLE high) / WAIT (frame in flight) sequence.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WR_EN,
  input  logic [31:0]        WR_DATA,
  input  logic [1:0]         WR_LINES,
  output logic               FULL,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               OVERFLOW,
  output logic               ENABLE,
  output logic [1:0]         I2CLINES,
  output logic [15:0]        I2CDATA12,
  output logic [15:0]        I2CDATA34,
  output logic               BUSY,
  output logic               DONE
);

  // Zero-length phases collapse to a single cycle
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES == 0) ? CNT_W'(1) : CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? CNT_W'(1) : CNT_W'(WAIT_CYCLES);

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pop_c;
  i2c_cmd_t         wr_cmd;
  i2c_cmd_t         head;
  logic [CMD_W-1:0] head_raw;

  assign wr_cmd = '{lines: WR_LINES, data12: WR_DATA[31:16], data34: WR_DATA[15:0]};
  assign head   = head_raw;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (WR_EN),
    .push_data (wr_cmd),
    .pop       (pop_c),
    .head_c    (head_raw),
    .level     (LEVEL),
    .full      (FULL),
    .overflow  (OVERFLOW)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (LEVEL != '0) begin
          pop_c     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = ASSERT;
        cnt_nxt   = HOLD_LOAD;
      end
      ASSERT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = WAIT;
          cnt_nxt   = WAIT_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they line up with the state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ENABLE    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      I2CLINES  <= 2'b00;
      I2CDATA12 <= '0;
      I2CDATA34 <= '0;
    end else begin
      ENABLE <= (state_nxt == ASSERT);
      BUSY   <= (state_nxt != IDLE);
      DONE   <= (state == WAIT) && (state_nxt == IDLE);
      if (pop_c) begin
        I2CLINES  <= head.lines;
        I2CDATA12 <= head.data12;
        I2CDATA34 <= head.data34;
      end else if (state_nxt == IDLE) begin
        I2CLINES <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with DEPTH=4, HOLD_CYCLES=4, WAIT_CYCLES=10.
module tb_i2c_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR_EN = 1'b0;
  logic [31:0] WR_DATA = '0;
  logic [1:0]  WR_LINES = '0;
  logic        FULL;
  logic [6:0]  LEVEL;
  logic        OVERFLOW;
  logic        ENABLE;
  logic [1:0]  I2CLINES;
  logic [15:0] I2CDATA12;
  logic [15:0] I2CDATA34;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic en_q = 1'b0;
  int          rise_cyc[$];
  logic [33:0] rise_pay[$];

  i2c_cmd_sequencer #(
    .DEPTH       (4),
    .HOLD_CYCLES (4),
    .WAIT_CYCLES (10)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .WR_LINES  (WR_LINES),
    .FULL      (FULL),
    .LEVEL     (LEVEL),
    .OVERFLOW  (OVERFLOW),
    .ENABLE    (ENABLE),
    .I2CLINES  (I2CLINES),
    .I2CDATA12 (I2CDATA12),
    .I2CDATA34 (I2CDATA34),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  // Record ENABLE rising edges with the payload presented, and DONE pulses
  always @(negedge CLK) begin
    if (ENABLE && !en_q) begin
      rise_cyc.push_back(cyc);
      rise_pay.push_back({I2CLINES, I2CDATA12, I2CDATA34});
    end
    if (DONE) done_cnt = done_cnt + 1;
    en_q = ENABLE;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] lines, input logic [31:0] data);
    WR_EN = 1'b1;
    WR_LINES = lines;
    WR_DATA = data;
    step(1);
    WR_EN = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((BUSY || LEVEL != 0) && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) check("idle_timeout", 64'(n), 64'(0));
    step(2);
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    rise_pay.delete();
    done_cnt = 0;
  endtask

  logic [1:0]  lines_tab [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [31:0] data_tab  [6] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
                                 32'h7777_8888, 32'h9999_AAAA, 32'hDEAD_BEEF};

  initial begin
    logic [19:0] en_vec, done_vec, lines_vec, busy_vec;

    // Reset state
    step(2);
    #1;
    check("rst_enable", 64'(ENABLE), 64'(0));
    check("rst_outs", {48'(0), I2CLINES, I2CDATA12[13:0]}, 64'(0));
    check("rst_data34", 64'(I2CDATA34), 64'(0));
    check("rst_flags", {59'(0), BUSY, DONE, FULL, OVERFLOW, ENABLE}, 64'(0));
    check("rst_level", 64'(LEVEL), 64'(0));
    RST = 1'b0;
    step(2);

    // Single command: timing of ENABLE, DONE and payload window
    clear_log();
    push(2'b10, 32'hA5A5_0F0F);
    en_vec = '0; done_vec = '0; lines_vec = '0; busy_vec = '0;
    check("single_level_after_push", 64'(LEVEL), 64'(1));
    for (int k = 0; k < 20; k++) begin
      en_vec[k]   = ENABLE;
      done_vec[k] = DONE;
      busy_vec[k] = BUSY;
      lines_vec[k] = (I2CLINES == 2'b10) && (I2CDATA12 == 16'hA5A5) && (I2CDATA34 == 16'h0F0F);
      if (k > 15) check("single_lines_released", 64'(I2CLINES), 64'(0));
      step(1);
    end
    check("single_enable_window", 64'(en_vec), 64'h0003C);
    check("single_done_pulse", 64'(done_vec), 64'h10000);
    check("single_payload_stable", 64'(lines_vec), 64'h0FFFE);
    check("single_busy", 64'(busy_vec), 64'h0FFFE);
    check("single_data_holds", {32'(0), I2CDATA12, I2CDATA34}, 64'hA5A5_0F0F);
    wait_idle();

    // Five back-to-back pushes, then a sixth into a full FIFO
    clear_log();
    for (int i = 0; i < 6; i++) begin
      WR_EN = 1'b1;
      WR_LINES = (i < 5) ? lines_tab[i] : 2'b11;
      WR_DATA = data_tab[i];
      step(1);
      if (i == 4) begin
        check("fill_level", 64'(LEVEL), 64'(4));
        check("fill_full", 64'(FULL), 64'(1));
        check("fill_no_ovf", 64'(OVERFLOW), 64'(0));
      end
    end
    WR_EN = 1'b0;
    check("ovf_set", 64'(OVERFLOW), 64'(1));
    check("ovf_level", 64'(LEVEL), 64'(4));
    wait_idle();
    check("fill_rises", 64'(rise_cyc.size()), 64'(5));
    check("fill_dones", 64'(done_cnt), 64'(5));
    for (int i = 0; i < 5 && i < rise_pay.size(); i++) begin
      check($sformatf("fill_payload%0d", i), 64'(rise_pay[i]), 64'({lines_tab[i], data_tab[i]}));
      if (i > 0) check($sformatf("fill_spacing%0d", i), 64'(rise_cyc[i] - rise_cyc[i-1]), 64'(16));
    end
    check("ovf_sticky", 64'(OVERFLOW), 64'(1));

    // Clear overflow, then push in the same cycle as the IDLE pop
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(1);
    check("ovf_cleared", 64'(OVERFLOW), 64'(0));
    clear_log();
    push(2'b01, 32'hCAFE_0001);
    push(2'b11, 32'hCAFE_0002);
    check("pushpop_level", 64'(LEVEL), 64'(1));
    wait_idle();
    check("pushpop_rises", 64'(rise_cyc.size()), 64'(2));
    if (rise_pay.size() == 2) begin
      check("pushpop_first", 64'(rise_pay[0]), 64'({2'b01, 32'hCAFE_0001}));
      check("pushpop_second", 64'(rise_pay[1]), 64'({2'b11, 32'hCAFE_0002}));
    end

    // Reset in the 6th WAIT cycle with two entries queued
    clear_log();
    WR_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WR_LINES = 2'b10;
      WR_DATA = data_tab[i];
      step(1);
    end
    WR_EN = 1'b0;
    step(9);
    check("midwait_busy", 64'(BUSY), 64'(1));
    check("midwait_level", 64'(LEVEL), 64'(2));
    RST = 1'b1;
    #1;
    check("rst_async_lines", 64'(I2CLINES), 64'(0));
    check("rst_async_level", 64'(LEVEL), 64'(0));
    check("rst_async_enable", 64'(ENABLE), 64'(0));
    step(1);
    RST = 1'b0;
    clear_log();
    step(50);
    check("post_rst_rises", 64'(rise_cyc.size()), 64'(0));
    check("post_rst_dones", 64'(done_cnt), 64'(0));
    check("post_rst_busy", 64'(BUSY), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning command FIFO depth in entries (power of two, 2..64).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 131072, meaning CLK cycles ENABLE is held high per command.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 6291456, meaning CLK cycles with ENABLE low after the hold phase, covering the 168-bit transmitter frame.
REQ-004 The block SHALL have port CLK, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1, meaning the reset; asynchronous and active-high.
REQ-006 The block SHALL have port WR_EN, input, 1, meaning push one command this cycle.
REQ-007 The block SHALL have port WR_DATA, input, 32, meaning command payload; [31:16] maps to I2CDATA12 and [15:0] to I2CDATA34.
REQ-008 The block SHALL have port WR_LINES, input, 2, meaning the bus-select mask for the command.
REQ-009 The block SHALL have port FULL, output, 1, meaning the FIFO holds DEPTH entries.
REQ-010 The block SHALL have port LEVEL, output, 7, meaning the current FIFO occupancy.
REQ-011 The block SHALL have port OVERFLOW, output, 1, meaning sticky flag set when a push is attempted while full.
REQ-012 The block SHALL have port ENABLE, output, 1, meaning the start request to the I2C transmitter.
REQ-013 The block SHALL have port I2CLINES, output, 2, meaning the bus select to the transmitter.
REQ-014 The block SHALL have ports I2CDATA12 and I2CDATA34, output, 16 each, meaning the frame payload to the transmitter.
REQ-015 The block SHALL have port BUSY, output, 1, meaning the state is not IDLE.
REQ-016 The block SHALL have port DONE, output, 1, meaning a one-cycle pulse when a command's WAIT phase ends.

Function
REQ-017 The FIFO SHALL store {WR_LINES, WR_DATA} (34 bits) and accept a push when WR_EN=1 and FULL=0; LEVEL SHALL update on the next edge.
REQ-018 A push while FULL=1 SHALL be dropped with FIFO contents unchanged, and OVERFLOW SHALL be set until reset.
REQ-019 A simultaneous push and pop SHALL leave LEVEL unchanged and SHALL be legal at full and at empty-plus-one; pointers wrap modulo DEPTH.
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD, ASSERT and WAIT.
REQ-021 In IDLE with LEVEL>0, the FSM SHALL pop the head entry and go to LOAD on the next edge.
REQ-022 LOAD SHALL last 1 cycle and register the popped entry onto I2CLINES, I2CDATA12 and I2CDATA34, then go to ASSERT.
REQ-023 ASSERT SHALL drive ENABLE=1 for exactly HOLD_CYCLES cycles, then go to WAIT.
REQ-024 WAIT SHALL drive ENABLE=0 for exactly WAIT_CYCLES cycles; on the last cycle DONE=1 and the next state SHALL be IDLE.
REQ-025 I2CLINES and both I2CDATA ports SHALL stay stable from LOAD through the end of WAIT, because the transmitter gates its line outputs combinationally with I2CLINES.
REQ-026 In IDLE, I2CLINES SHALL be 2'b00 so both buses are released; I2CDATA SHALL hold its last value.
REQ-027 The command-to-command ENABLE rising-edge spacing SHALL be at least 1+HOLD_CYCLES+WAIT_CYCLES+1 cycles; back-to-back commands SHALL pass through IDLE for 1 cycle.
REQ-028 ENABLE SHALL be driven directly from a register, with no combinational path from WR_EN.
REQ-029 The phase counter SHALL be 24 bits wide and count down to 1; a parameter of 0 SHALL be treated as 1.
REQ-030 A command with WR_LINES=2'b00 SHALL still be sequenced normally, producing no bus activity.

Reset
REQ-031 While RST=1, the block SHALL force state=IDLE, ENABLE=0, I2CLINES=0, I2CDATA12/34=0, DONE=0, BUSY=0, LEVEL=0, FULL=0, OVERFLOW=0, empty FIFO and counter=0, asynchronously.
REQ-032 Reset asserted mid-ASSERT or mid-WAIT SHALL drop ENABLE and I2CLINES at once, discard the command with no DONE, and flush the queued entries.

Structure
REQ-033 Shared package i2c_pkg SHALL hold the state encoding (IDLE=0, LOAD=1, ASSERT=2, WAIT=3), the default HOLD_CYCLES/WAIT_CYCLES, and I2C_FRAME_BITS=168.
REQ-034 The FIFO SHALL be one sub-module, i2c_cmd_fifo (parameter DEPTH, WIDTH=34, async active-high reset); the FSM and counter SHALL live in the top level.

Verification (DEPTH=4, HOLD_CYCLES=4, WAIT_CYCLES=10)
REQ-035 Push one command {WR_LINES=2'b10, WR_DATA=32'hA5A5_0F0F} -> ENABLE high for exactly 4 cycles starting 2 cycles after the push; I2CLINES=2'b10, I2CDATA12=16'hA5A5, I2CDATA34=16'h0F0F stable until DONE; DONE is a single pulse 14 cycles after ENABLE rises; then I2CLINES=0.
REQ-036 Push 5 commands in consecutive cycles while idle -> the first pops, 4 are queued, FULL never drops a command, OVERFLOW=0; a 6th push while FULL=1 -> OVERFLOW=1 and LEVEL stays 4.
REQ-037 Queue 3 commands -> the ENABLE rising edges are exactly 16 cycles apart, and the data order matches the push order.
REQ-038 Push in the same cycle as an IDLE pop at LEVEL=1 -> LEVEL stays 1 and there is no loss or duplicate.
REQ-039 Assert RST for 1 cycle at the 6th WAIT cycle with 2 queued entries -> ENABLE=0, I2CLINES=0, LEVEL=0, no DONE, and no ENABLE for 50 cycles after release.
REQ-040 Run with default parameters and the real transmitter model -> all 168 frame bits complete on the selected bus before the next ENABLE rising edge.
